// File: rtl/writeback_stage.sv
// Write-back stage: takes completed instructions, waits on data memory for
// loads, size-extends load data and drives the register file write port.
//
// Ports:
//   clock, nReset       clock and asynchronous active-low reset
//   inValid / inReady   instruction handshake from execute/memory
//   inRegWrite          instruction writes a destination register
//   inMemToReg          result comes from data memory (load)
//   inLoadSize          00 word, 01 half zero-ext, 10 byte zero-ext, 11 word
//   inDestReg           destination register index
//   inAluResult         result for non-load instructions
//   memReadValid/Data   load data return from data memory
//   regWrite            register file write enable (one cycle per write)
//   writeRegister/Data  register file write address and data
//   pendingValid/Reg    outstanding destination for hazard detection
//   memError            one-cycle pulse when a load times out
module writeback_stage #(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [4:0] ZERO_REG    = 5'd31
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        inValid,
    output logic        inReady,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    input  logic [1:0]  inLoadSize,
    input  logic [4:0]  inDestReg,
    input  logic [31:0] inAluResult,
    input  logic        memReadValid,
    input  logic [31:0] memReadData,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        pendingValid,
    output logic [4:0]  pendingReg,
    output logic        memError
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic        cap_rw;
    logic [1:0]  cap_size;
    logic        xfer;
    logic        expire;
    logic        dest_live;
    logic [31:0] ext_data;

    assign xfer      = inValid && inReady;
    assign dest_live = cap_rw && (pendingReg != ZERO_REG);

    // Expiry is the last waiting cycle with no data; data in that
    // same cycle takes priority.
    assign expire = (state_q == WAIT_MEM) && !memReadValid &&
                    (cnt_q == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        ext_data = memReadData;
        unique case (cap_size)
            2'b01:   ext_data = {16'b0, memReadData[15:0]};
            2'b10:   ext_data = {24'b0, memReadData[7:0]};
            default: ext_data = memReadData;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE, WRITE: begin
                if (xfer) begin
                    if (inMemToReg)      state_d = WAIT_MEM;
                    else if (inRegWrite) state_d = WRITE;
                    else                 state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (memReadValid) state_d = cap_rw ? WRITE : IDLE;
                else if (expire)  state_d = IDLE;
                else              state_d = WAIT_MEM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        inReady      = (state_q != WAIT_MEM);
        regWrite     = (state_q == WRITE) && dest_live;
        pendingValid = (state_q != IDLE) && dest_live;
    end

    // Captured fields, write port registers and timeout counter
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q         <= 8'd0;
            cap_rw        <= 1'b0;
            cap_size      <= 2'b00;
            pendingReg    <= 5'd0;
            writeRegister <= 5'd0;
            writeData     <= 32'd0;
            memError      <= 1'b0;
        end else begin
            memError <= expire;
            if (xfer) begin
                cap_rw     <= inRegWrite;
                cap_size   <= inLoadSize;
                pendingReg <= inDestReg;
                cnt_q      <= 8'd0;
                if (!inMemToReg && inRegWrite) begin
                    writeRegister <= inDestReg;
                    writeData     <= inAluResult;
                end
            end else if (state_q == WAIT_MEM) begin
                if (memReadValid) begin
                    if (cap_rw) begin
                        writeRegister <= pendingReg;
                        writeData     <= ext_data;
                    end
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal
// expectations, then random traffic against a transaction-level model.
module tb_writeback_stage;

    localparam int MEM_TIMEOUT = 15;
    localparam logic [4:0] ZR = 5'd31;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        inRegWrite = 1'b0;
    logic        inMemToReg = 1'b0;
    logic [1:0]  inLoadSize = 2'b00;
    logic [4:0]  inDestReg = 5'd0;
    logic [31:0] inAluResult = 32'd0;
    logic        memReadValid = 1'b0;
    logic [31:0] memReadData = 32'd0;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        pendingValid;
    logic [4:0]  pendingReg;
    logic        memError;

    writeback_stage #(.MEM_TIMEOUT(MEM_TIMEOUT), .ZERO_REG(ZR)) dut (
        .clock(clock), .nReset(nReset),
        .inValid(inValid), .inReady(inReady),
        .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
        .inLoadSize(inLoadSize), .inDestReg(inDestReg),
        .inAluResult(inAluResult),
        .memReadValid(memReadValid), .memReadData(memReadData),
        .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .pendingValid(pendingValid),
        .pendingReg(pendingReg), .memError(memError)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: an outstanding load (if any) and the write visible this cycle.
    bit          m_load;
    bit          m_load_rw;
    logic [4:0]  m_load_dest;
    logic [1:0]  m_load_size;
    int          m_wait;
    bit          m_wr;
    logic [4:0]  m_wr_dest;
    logic [31:0] m_wr_data;
    bit          m_err;
    logic [4:0]  m_last_dest;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_load = 0; m_load_rw = 0; m_load_dest = 0; m_load_size = 0;
        m_wait = 0; m_wr = 0; m_wr_dest = 0; m_wr_data = 0;
        m_err = 0; m_last_dest = 0;
    endtask

    function automatic logic [31:0] extend(logic [1:0] sz, logic [31:0] d);
        case (sz)
            2'b01:   return d & 32'h0000FFFF;
            2'b10:   return d & 32'h000000FF;
            default: return d;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs presented.
    task automatic model_step();
        bit nwr;
        bit nerr;
        nwr = 0;
        nerr = 0;
        if (!nReset) begin
            model_reset();
            return;
        end
        if (!m_load) begin
            if (inValid) begin
                m_last_dest = inDestReg;
                if (inMemToReg) begin
                    m_load      = 1;
                    m_load_rw   = inRegWrite;
                    m_load_dest = inDestReg;
                    m_load_size = inLoadSize;
                    m_wait      = 0;
                end else if (inRegWrite && inDestReg != ZR) begin
                    nwr = 1;
                    m_wr_dest = inDestReg;
                    m_wr_data = inAluResult;
                end
            end
        end else if (memReadValid) begin
            m_load = 0;
            if (m_load_rw && m_load_dest != ZR) begin
                nwr = 1;
                m_wr_dest = m_load_dest;
                m_wr_data = extend(m_load_size, memReadData);
            end
        end else begin
            m_wait++;
            if (m_wait == MEM_TIMEOUT) begin
                m_load = 0;
                nerr = 1;
            end
        end
        m_wr  = nwr;
        m_err = nerr;
    endtask

    task automatic compare();
        bit pv;
        pv = m_wr || (m_load && m_load_rw && m_load_dest != ZR);
        check("inReady", inReady, !m_load);
        check("regWrite", regWrite, m_wr);
        check("pendingValid", pendingValid, pv);
        check("pendingReg", pendingReg, m_last_dest);
        check("memError", memError, m_err);
        if (m_wr) begin
            check("writeRegister", writeRegister, m_wr_dest);
            check("writeData", writeData, m_wr_data);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic set_op(bit v, bit rw, bit m2r, logic [1:0] sz,
                          logic [4:0] d, logic [31:0] alu);
        inValid = v; inRegWrite = rw; inMemToReg = m2r;
        inLoadSize = sz; inDestReg = d; inAluResult = alu;
    endtask

    task automatic idle_in();
        inValid = 0;
        memReadValid = 0;
    endtask

    initial begin
        model_reset();
        nReset = 0;
        tick();
        tick();
        check("rst_regWrite", regWrite, 0);
        check("rst_inReady", inReady, 1);
        check("rst_writeRegister", writeRegister, 0);
        check("rst_writeData", writeData, 0);
        check("rst_pendingReg", pendingReg, 0);
        nReset = 1;
        tick();

        // Single ALU write
        set_op(1, 1, 0, 2'b00, 5'd5, 32'hDEADBEEF);
        tick();
        idle_in();
        check("alu_rw", regWrite, 1);
        check("alu_reg", writeRegister, 5);
        check("alu_data", writeData, 32'hDEADBEEF);
        check("alu_pend", pendingValid, 1);
        tick();
        check("alu_one_cycle", regWrite, 0);

        // Back-to-back ALU writes
        for (int i = 1; i <= 3; i++) begin
            set_op(1, 1, 0, 2'b00, 5'(i), 32'(i * 16'h1111));
            check("b2b_ready", inReady, 1);
            tick();
            check("b2b_rw", regWrite, 1);
            check("b2b_reg", writeRegister, 5'(i));
        end
        idle_in();
        tick();

        // Byte then halfword load, data after 3 cycles
        for (int k = 0; k < 2; k++) begin
            set_op(1, 1, 1, k == 0 ? 2'b10 : 2'b01, 5'd7, 32'h0);
            tick();
            idle_in();
            repeat (3) begin
                check("ld_wait_ready", inReady, 0);
                tick();
            end
            memReadValid = 1;
            memReadData  = 32'h123456F0;
            tick();
            memReadValid = 0;
            check("ld_rw", regWrite, 1);
            check("ld_reg", writeRegister, 7);
            check("ld_data", writeData, k == 0 ? 32'h000000F0 : 32'h000056F0);
            tick();
        end

        // Write to zero register suppressed, next op accepted
        set_op(1, 1, 0, 2'b00, ZR, 32'h5);
        tick();
        check("zr_rw", regWrite, 0);
        check("zr_pend", pendingValid, 0);
        check("zr_ready", inReady, 1);
        set_op(1, 1, 0, 2'b00, 5'd4, 32'h9);
        tick();
        idle_in();
        check("zr_next_rw", regWrite, 1);
        check("zr_next_data", writeData, 32'h9);
        tick();

        // Load timeout
        set_op(1, 1, 1, 2'b00, 5'd9, 32'h0);
        tick();
        idle_in();
        repeat (MEM_TIMEOUT - 1) tick();
        check("to_no_err_yet", memError, 0);
        check("to_ready_low", inReady, 0);
        tick();
        check("to_err", memError, 1);
        check("to_no_write", regWrite, 0);
        check("to_ready", inReady, 1);
        tick();
        check("to_err_pulse", memError, 0);

        // Data on the final waiting cycle wins
        set_op(1, 1, 1, 2'b00, 5'd10, 32'h0);
        tick();
        idle_in();
        repeat (MEM_TIMEOUT - 1) tick();
        memReadValid = 1;
        memReadData  = 32'hCAFEF00D;
        tick();
        memReadValid = 0;
        check("late_rw", regWrite, 1);
        check("late_data", writeData, 32'hCAFEF00D);
        check("late_err", memError, 0);
        tick();

        // Reset while waiting on memory
        set_op(1, 1, 1, 2'b00, 5'd12, 32'h0);
        tick();
        idle_in();
        tick();
        nReset = 0;
        tick();
        nReset = 1;
        memReadValid = 1;
        memReadData  = 32'h11112222;
        tick();
        memReadValid = 0;
        check("rstw_rw", regWrite, 0);
        check("rstw_reg", writeRegister, 0);
        check("rstw_data", writeData, 0);
        check("rstw_pend", pendingValid, 0);
        check("rstw_preg", pendingReg, 0);
        check("rstw_ready", inReady, 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] d;
            d = ($urandom_range(0, 7) == 0) ? ZR : 5'($urandom);
            set_op($urandom_range(0, 9) < 6, 1'($urandom),
                   $urandom_range(0, 9) < 3, 2'($urandom), d, $urandom);
            memReadValid = ($urandom_range(0, 19) < 3);
            memReadData  = $urandom;
            nReset = ($urandom_range(0, 499) != 0);
            tick();
        end
        nReset = 1;
        idle_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Write-back stage of the ARM-LP datapath. Accepts completed instructions from the execute/memory stage over a valid/ready handshake, waits for data memory on loads, size-extends load data, and drives the register file's write port (`regWrite`, `writeRegister`, `writeData`) that operand preparation consumes. It also exports the pending destination register so hazard logic can stall dependent reads.

## Interface
- `MEM_TIMEOUT`, default 15: cycles allowed in WAIT_MEM before a load is abandoned; legal range 1..255.
- `ZERO_REG`, default 31: register index hard-wired to zero (XZR); writes to it are suppressed.

- `clock`  in  1  main clock; all state changes on the rising edge.
- `nReset`  in  1  reset, asynchronous and active-low.
- `inValid`  in  1  execute/memory stage presents an instruction.
- `inReady`  out  1  block accepts the instruction this cycle.
- `inRegWrite`  in  1  instruction writes a destination register.
- `inMemToReg`  in  1  result comes from data memory (load).
- `inLoadSize`  in  2  00 word, 01 halfword zero-extend, 10 byte zero-extend, 11 treated as word.
- `inDestReg`  in  5  destination register index.
- `inAluResult`  in  32  ALU result for non-load instructions.
- `memReadValid`  in  1  data memory returns load data this cycle.
- `memReadData`  in  32  load data.
- `regWrite`  out  1  register file write enable, one cycle per write.
- `writeRegister`  out  5  register file write address.
- `writeData`  out  32  register file write data.
- `pendingValid`  out  1  a register write is outstanding.
- `pendingReg`  out  5  destination of the outstanding write.
- `memError`  out  1  one-cycle pulse on load timeout.

## Operation
- States: IDLE, WAIT_MEM, WRITE. Transfer occurs when `inValid && inReady`. Capture `inRegWrite`, `inMemToReg`, `inLoadSize`, `inDestReg`, `inAluResult`.
- `inReady` = 1 in IDLE and WRITE, 0 in WAIT_MEM.
- On transfer from IDLE or WRITE:
  - `inMemToReg`=1 -> WAIT_MEM, timeout counter cleared.
  - `inMemToReg`=0 and `inRegWrite`=1 -> WRITE with data = `inAluResult`.
  - `inMemToReg`=0 and `inRegWrite`=0 -> IDLE, nothing written.
- No transfer: WRITE -> IDLE.
- WAIT_MEM:
  - On `memReadValid`, latch the extended data. Byte: {24'b0, d[7:0]}. Halfword: {16'b0, d[15:0]}. Word: d.
  - Then -> WRITE if captured regWrite=1, else -> IDLE. The load is consumed either way.
  - Otherwise the counter increments. When MEM_TIMEOUT consecutive cycles pass without valid: `memError` pulses one cycle, state -> IDLE, no write.
  - `memReadValid` in the same cycle as expiry: data wins, no error.
- `memReadValid` outside WAIT_MEM is ignored.
- WRITE: `regWrite` = 1 unless captured dest == ZERO_REG, in which case `regWrite` = 0. State, handshake, and timing are unchanged.
- `writeRegister` and `writeData` are registered and hold their last values outside WRITE.
- `pendingValid` = 1 in WAIT_MEM or WRITE when captured regWrite=1 and dest != ZERO_REG. `pendingReg` = captured dest, held otherwise.

## Timing
- Reset, asserted at any time: state IDLE, counter 0, `regWrite` 0, `writeRegister` 0, `writeData` 0, `pendingValid` 0, `pendingReg` 0, `memError` 0. An in-flight load or write is dropped with no write issued.
- ALU instruction transferred at edge n: `regWrite` is high in the cycle following edge n, for exactly one cycle.
- Back-to-back ALU instructions sustain one write per cycle, because WRITE accepts the next instruction.
- Load: `memReadValid` sampled at edge m -> `regWrite` high in the cycle after edge m. Minimum transfer-to-write latency is 2 cycles.
- Register file writes on the rising edge that ends the `regWrite` cycle.

## Test plan
- Reset, then ALU op dest=5, result 0xDEADBEEF -> after 1 cycle `regWrite`=1, `writeRegister`=5, `writeData`=0xDEADBEEF for one cycle. `pendingValid` is high in that cycle.
- Three consecutive ALU ops (dest 1, 2, 3) with `inValid` held -> `inReady` stays 1 and three consecutive write cycles occur, dest 1, 2, 3 in order.
- Byte load dest=7, memory returns 0x123456F0 after 3 cycles -> `inReady`=0 while waiting. Then `writeData`=0x000000F0 and `writeRegister`=7. A halfword load of the same data gives 0x000056F0.
- ALU op dest=31 value 0x5 -> no `regWrite` pulse, `pendingValid` stays 0, next instruction accepted normally.
- Load with no response for 15 cycles -> `memError` pulses once, no write, `inReady` returns to 1. Repeat with valid on the 15th cycle -> normal write, no error.
- `nReset` low during WAIT_MEM, then `memReadValid` after release -> no write, all outputs at reset values, state IDLE.
